// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_sequencer
// Purpose  : Fetch/wait/execute controller owning the PC and instruction
//            register; gates GPR writes to EXEC and resolves JMP/HLT.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic [23:0]       ir,
    input  logic              dec_gpr_w_enable,
    output logic              gpr_w_enable,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              step_done
);

    localparam logic [7:0]        c_op_jmp = 8'h20;
    localparam logic [7:0]        c_op_hlt = 8'h21;
    localparam logic [ADDR_W-1:0] c_pc_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        c_st_idle  = 3'd0,
        c_st_fetch = 3'd1,
        c_st_wait  = 3'd2,
        c_st_exec  = 3'd3,
        c_st_halt  = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [23:0]       r_ir;
    logic              r_step_mode;
    logic              r_step_done;
    logic              r_busy;
    logic              r_halted;

    logic [7:0]        w_opcode;
    logic [ADDR_W-1:0] w_target;

    assign w_opcode = r_ir[23:16];
    assign w_target = ADDR_W'(r_ir[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_pc        <= RESET_PC;
            r_ir        <= 24'h0;
            r_step_mode <= 1'b0;
            r_step_done <= 1'b0;
            r_busy      <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_step_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (run) begin
                        r_state     <= c_st_fetch;
                        r_step_mode <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (step) begin
                        r_state     <= c_st_fetch;
                        r_step_mode <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                c_st_fetch: begin
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    r_ir    <= rom_data;
                    r_state <= c_st_exec;
                end
                c_st_exec: begin
                    if (w_opcode == c_op_hlt) begin
                        r_state  <= c_st_halt;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= (w_opcode == c_op_jmp) ? w_target : r_pc + c_pc_one;
                        if (r_step_mode) begin
                            r_step_done <= 1'b1;
                            r_state     <= c_st_idle;
                            r_busy      <= 1'b0;
                        end else if (run) begin
                            r_state <= c_st_fetch;
                        end else begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                c_st_halt: begin
                    // Sticky until reset; run/step are deliberately ignored.
                    r_state <= c_st_halt;
                end
                default: begin
                    r_state  <= c_st_idle;
                    r_busy   <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Reset masks the strobe in the same cycle so an aborted EXEC never writes.
    assign gpr_w_enable = (r_state == c_st_exec) & dec_gpr_w_enable & ~rst;

    assign rom_addr  = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign step_done = r_step_done;

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/execute controller for the single-cycle CPU datapath. It owns the program counter, drives the ROM address, and captures the 24-bit instruction word into an instruction register that feeds the decoder's `rom_data` input. It gates the decoder's GPR write strobe so register writes happen in exactly one cycle per instruction. It also resolves the control-flow opcodes `JMP` and `HLT` itself.

## Interface
Parameters:
- `ADDR_W`, 8: PC and ROM address width.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: level. While high, the sequencer executes continuously.
- `step`  in  1: one-cycle pulse. Executes exactly one instruction when idle.
- `rom_addr`  out  ADDR_W: equals `pc` (combinational from the PC register).
- `rom_data`  in  24: synchronous ROM output, valid one cycle after `rom_addr`.
- `ir`  out  24: instruction register, connected to decoder `rom_data`.
- `dec_gpr_w_enable`  in  1: decoder's raw `gpr_w_enable`.
- `gpr_w_enable`  out  1: gated write enable to the GPR file.
- `pc`  out  ADDR_W: current program counter.
- `busy`  out  1: high in FETCH, WAIT and EXEC.
- `halted`  out  1: high in HALT.
- `step_done`  out  1: one-cycle pulse when a single-stepped instruction retires.

## Operation
- Opcode field is `ir[23:16]`; the jump target is `ir[7:0]` truncated to ADDR_W.
- Opcodes are defined in global_params.vh: `JMP` = 8'h20, `HLT` = 8'h21. The decoder performs no GPR write for either.
- States: IDLE, FETCH, WAIT, EXEC, HALT.
- Reset values:
  - state = IDLE, `pc` = RESET_PC, `ir` = 24'h0 (NOP).
  - `gpr_w_enable`, `busy`, `halted`, `step_done` all 0.
  - internal `step_mode` = 0.
- IDLE:
  - `run`=1 → FETCH, `step_mode`=0.
  - else `step`=1 → FETCH, `step_mode`=1.
  - If `run` and `step` are both high, `run` wins.
- FETCH: `rom_addr`=`pc` is presented; → WAIT.
- WAIT: `ir` <= `rom_data`; → EXEC.
- EXEC:
  - `gpr_w_enable` = `dec_gpr_w_enable` & ~`rst`. It is 0 in every other state.
  - `JMP`: `pc` <= target.
  - `HLT`: `pc` unchanged; → HALT.
  - Any other opcode: `pc` <= `pc`+1, modulo 2^ADDR_W (wraps all-ones → 0).
  - Next state (non-HLT):
    - `step_mode`=1 → assert `step_done`, → IDLE.
    - else `run`=1 → FETCH.
    - else → IDLE.
- HALT: `halted`=1; `run` and `step` are ignored. Only `rst` exits.
- `step` pulses outside IDLE are ignored and not queued.
- `run` deasserted mid-instruction: the current instruction completes, including its write, then → IDLE.
- `ir` holds its value outside WAIT. The decoder outputs are therefore stable through EXEC.

## Timing
- Each instruction takes exactly 3 cycles: FETCH, WAIT, EXEC. Continuous-run throughput is 1 instruction per 3 cycles.
- The GPR write lands on the rising edge that ends EXEC. The next instruction's FETCH uses the updated `pc` in the following cycle.
- After `run` rises in IDLE, the first `gpr_w_enable` appears in the 3rd cycle after the sampling edge.
- `step_done` is high during the cycle after EXEC, coincident with IDLE.
- Reset during EXEC: `gpr_w_enable` is forced 0 combinationally in that cycle. All state returns to reset values on the edge.
- Reset during HALT clears `halted` on the next edge.

## Test plan
- Reset then `run`=1 with ROM[0]=LDR r1,8'h05 and ROM[1]=INC r1:
  - `gpr_w_enable` pulses at cycles 3 and 6.
  - r1 ends at 8'h06.
  - `pc`=2 after the second EXEC.
- Single step: `run`=0, one `step` pulse.
  - Exactly one EXEC occurs and `step_done` pulses once.
  - `pc` goes 0→1.
  - A second `step` issued while busy is ignored.
- ROM[3]=JMP 8'h03 with `run`=1:
  - `pc` stays 3 indefinitely.
  - `gpr_w_enable` is never asserted.
  - `busy` stays 1.
- ROM[2]=HLT:
  - `halted`=1 with `pc`=2.
  - `run`/`step` toggling has no effect.
  - `rst` returns `pc` to 0 and `halted` to 0.
- PC wrap: RESET_PC=8'hFF with ROM[FF]=NOP.
  - After one step, `pc`=8'h00.
- `rst` asserted during EXEC of an ADD with `dec_gpr_w_enable`=1:
  - `gpr_w_enable` is 0 in that cycle.
  - Next cycle: IDLE, `pc`=RESET_PC, `ir`=0.
